// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: drives a 4-digit multiplexed 7-segment display.
// Two background pages alternate on a fixed period. A transient message
// pre-empts them for a fixed hold time, then the shown page resumes.
// Digit scan, hex decode, decimal point and blanking are generated here.
module seg_display_scheduler #(
  parameter int CLK_DIV    = 50000,
  parameter int ALT_TICKS  = 1000,
  parameter int HOLD_TICKS = 2000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        enable,
  input  logic        bg_wr,
  input  logic        bg_page,
  input  logic [15:0] bg_digits,
  input  logic [3:0]  bg_dp,
  input  logic [3:0]  bg_blank,
  input  logic        msg_req,
  input  logic [15:0] msg_digits,
  input  logic [3:0]  msg_dp,
  input  logic [3:0]  msg_blank,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic [1:0]  active_src,
  output logic [7:0]  seg,
  output logic [3:0]  sel
);

  localparam int PW = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
  localparam int AW = (ALT_TICKS > 1)  ? $clog2(ALT_TICKS)  : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [AW-1:0] ALT_LAST   = AW'(ALT_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);

  // Encoding doubles as the active_src code driven to the pins.
  typedef enum logic [1:0] {
    ST_BLANK    = 2'd0,
    ST_SHOW_A   = 2'd1,
    ST_SHOW_B   = 2'd2,
    ST_SHOW_MSG = 2'd3
  } state_t;

  // Hex nibble to segment pattern, bit0 = a ... bit6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3f;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5b;
      4'h3:    pat = 7'h4f;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6d;
      4'h6:    pat = 7'h7d;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7f;
      4'h9:    pat = 7'h6f;
      4'ha:    pat = 7'h77;
      4'hb:    pat = 7'h7c;
      4'hc:    pat = 7'h39;
      4'hd:    pat = 7'h5e;
      4'he:    pat = 7'h79;
      4'hf:    pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  // Timing
  logic [PW-1:0] presc_r;
  logic          tick_s;
  logic [1:0]    scan_idx_r;

  // Scheduler state
  state_t        state_r, state_nxt_s;
  logic [AW-1:0] alt_cnt_r, alt_cnt_nxt_s;
  logic [HW-1:0] hold_cnt_r, hold_cnt_nxt_s;
  logic          resume_page_r, resume_page_nxt_s;  // 0 = page A, 1 = page B
  logic          accept_s;

  // Page and message storage
  logic [15:0]   pa_digits_r, pb_digits_r, mg_digits_r;
  logic [3:0]    pa_dp_r, pb_dp_r, mg_dp_r;
  logic [3:0]    pa_blank_r, pb_blank_r, mg_blank_r;

  // Output path
  logic [15:0]   cur_digits_s;
  logic [3:0]    cur_dp_s;
  logic [3:0]    cur_blank_s;
  logic [3:0]    cur_nib_s;
  logic [7:0]    seg_nxt_s;
  logic [3:0]    sel_nxt_s;
  logic [7:0]    seg_r;
  logic [3:0]    sel_r;
  logic [1:0]    active_src_r;
  logic          msg_ack_r;
  logic          msg_busy_r;

  assign tick_s = (presc_r == PRESC_LAST);

  // Free-running prescaler producing the scan tick.
  always_ff @(posedge clk) begin
    if (RST) begin
      presc_r <= {PW{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Digit scan index advances once per tick in every state.
  always_ff @(posedge clk) begin
    if (RST) begin
      scan_idx_r <= 2'd0;
    end else if (tick_s) begin
      scan_idx_r <= scan_idx_r + 2'd1;
    end else begin
      scan_idx_r <= scan_idx_r;
    end
  end

  // Next-state logic: enable dominates, then message accept, then tick-driven timing.
  always_comb begin
    state_nxt_s       = state_r;
    alt_cnt_nxt_s     = alt_cnt_r;
    hold_cnt_nxt_s    = hold_cnt_r;
    resume_page_nxt_s = resume_page_r;
    accept_s          = 1'b0;
    if (!enable) begin
      // Pending requests are dropped silently; both timers restart.
      state_nxt_s    = ST_BLANK;
      alt_cnt_nxt_s  = {AW{1'b0}};
      hold_cnt_nxt_s = {HW{1'b0}};
    end else begin
      case (state_r)
        ST_BLANK: begin
          state_nxt_s = ST_SHOW_A;
        end
        ST_SHOW_A, ST_SHOW_B: begin
          if (msg_req) begin
            // Accept freezes the alternation counter at its current value.
            accept_s          = 1'b1;
            state_nxt_s       = ST_SHOW_MSG;
            hold_cnt_nxt_s    = {HW{1'b0}};
            resume_page_nxt_s = (state_r == ST_SHOW_B);
          end else if (tick_s) begin
            if (alt_cnt_r == ALT_LAST) begin
              alt_cnt_nxt_s = {AW{1'b0}};
              state_nxt_s   = (state_r == ST_SHOW_A) ? ST_SHOW_B : ST_SHOW_A;
            end else begin
              alt_cnt_nxt_s = alt_cnt_r + AW'(1);
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_SHOW_MSG: begin
          if (msg_req) begin
            // Retrigger wins even on the final hold tick; resume page kept.
            accept_s       = 1'b1;
            hold_cnt_nxt_s = {HW{1'b0}};
          end else if (tick_s) begin
            if (hold_cnt_r == HOLD_LAST) begin
              hold_cnt_nxt_s = {HW{1'b0}};
              state_nxt_s    = resume_page_r ? ST_SHOW_B : ST_SHOW_A;
            end else begin
              hold_cnt_nxt_s = hold_cnt_r + HW'(1);
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        default: begin
          state_nxt_s = ST_BLANK;
        end
      endcase
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_r       <= ST_BLANK;
      alt_cnt_r     <= {AW{1'b0}};
      hold_cnt_r    <= {HW{1'b0}};
      resume_page_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      alt_cnt_r     <= alt_cnt_nxt_s;
      hold_cnt_r    <= hold_cnt_nxt_s;
      resume_page_r <= resume_page_nxt_s;
    end
  end

  // Background page registers; writes land in any state.
  always_ff @(posedge clk) begin
    if (RST) begin
      pa_digits_r <= 16'h0000;
      pa_dp_r     <= 4'h0;
      pa_blank_r  <= 4'hf;
      pb_digits_r <= 16'h0000;
      pb_dp_r     <= 4'h0;
      pb_blank_r  <= 4'hf;
    end else if (bg_wr && !bg_page) begin
      pa_digits_r <= bg_digits;
      pa_dp_r     <= bg_dp;
      pa_blank_r  <= bg_blank;
    end else if (bg_wr && bg_page) begin
      pb_digits_r <= bg_digits;
      pb_dp_r     <= bg_dp;
      pb_blank_r  <= bg_blank;
    end else begin
      pa_digits_r <= pa_digits_r;
      pb_digits_r <= pb_digits_r;
    end
  end

  // Message field capture on every accepted request.
  always_ff @(posedge clk) begin
    if (RST) begin
      mg_digits_r <= 16'h0000;
      mg_dp_r     <= 4'h0;
      mg_blank_r  <= 4'hf;
    end else if (accept_s) begin
      mg_digits_r <= msg_digits;
      mg_dp_r     <= msg_dp;
      mg_blank_r  <= msg_blank;
    end else begin
      mg_digits_r <= mg_digits_r;
    end
  end

  // Select the source shown by the current state and build the next digit image.
  always_comb begin
    cur_digits_s = pa_digits_r;
    cur_dp_s     = pa_dp_r;
    cur_blank_s  = pa_blank_r;
    seg_nxt_s    = 8'h00;
    sel_nxt_s    = 4'hf;
    case (state_r)
      ST_SHOW_B: begin
        cur_digits_s = pb_digits_r;
        cur_dp_s     = pb_dp_r;
        cur_blank_s  = pb_blank_r;
      end
      ST_SHOW_MSG: begin
        cur_digits_s = mg_digits_r;
        cur_dp_s     = mg_dp_r;
        cur_blank_s  = mg_blank_r;
      end
      default: begin
        cur_digits_s = pa_digits_r;
      end
    endcase
    cur_nib_s = cur_digits_s[{scan_idx_r, 2'b00} +: 4];
    if (state_r == ST_BLANK) begin
      seg_nxt_s = 8'h00;
      sel_nxt_s = 4'hf;
    end else begin
      // Decimal point is independent of the blank mask.
      seg_nxt_s = {cur_dp_s[scan_idx_r],
                   cur_blank_s[scan_idx_r] ? 7'h00 : hex_to_seg(cur_nib_s)};
      sel_nxt_s = ~(4'b0001 << scan_idx_r);
    end
  end

  // Registered pin outputs: scan image refreshes on tick, handshake every cycle.
  always_ff @(posedge clk) begin
    if (RST) begin
      seg_r        <= 8'h00;
      sel_r        <= 4'hf;
      active_src_r <= 2'd0;
      msg_ack_r    <= 1'b0;
      msg_busy_r   <= 1'b0;
    end else begin
      msg_ack_r  <= accept_s;
      msg_busy_r <= (state_nxt_s == ST_SHOW_MSG);
      if (tick_s) begin
        seg_r        <= seg_nxt_s;
        sel_r        <= sel_nxt_s;
        active_src_r <= state_r;
      end else begin
        seg_r        <= seg_r;
        sel_r        <= sel_r;
        active_src_r <= active_src_r;
      end
    end
  end

  assign seg        = seg_r;
  assign sel        = sel_r;
  assign active_src = active_src_r;
  assign msg_ack    = msg_ack_r;
  assign msg_busy   = msg_busy_r;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench for seg_display_scheduler with a behavioural reference model.
module tb_seg_display_scheduler;

  localparam int CLK_DIV    = 4;
  localparam int ALT_TICKS  = 16;
  localparam int HOLD_TICKS = 8;

  logic        clk;
  logic        RST;
  logic        enable;
  logic        bg_wr;
  logic        bg_page;
  logic [15:0] bg_digits;
  logic [3:0]  bg_dp;
  logic [3:0]  bg_blank;
  logic        msg_req;
  logic [15:0] msg_digits;
  logic [3:0]  msg_dp;
  logic [3:0]  msg_blank;
  logic        msg_ack;
  logic        msg_busy;
  logic [1:0]  active_src;
  logic [7:0]  seg;
  logic [3:0]  sel;

  int total;
  int bad;

  seg_display_scheduler #(
    .CLK_DIV(CLK_DIV), .ALT_TICKS(ALT_TICKS), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk(clk), .RST(RST), .enable(enable),
    .bg_wr(bg_wr), .bg_page(bg_page), .bg_digits(bg_digits),
    .bg_dp(bg_dp), .bg_blank(bg_blank),
    .msg_req(msg_req), .msg_digits(msg_digits), .msg_dp(msg_dp),
    .msg_blank(msg_blank),
    .msg_ack(msg_ack), .msg_busy(msg_busy), .active_src(active_src),
    .seg(seg), .sel(sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Mode: 0 blank, 1 page A, 2 page B, 3 message (same as active_src meaning).
  logic [6:0]  seg_tab [16];
  logic [15:0] pg_dig [2];
  logic [3:0]  pg_dp  [2];
  logic [3:0]  pg_blk [2];
  logic [15:0] mg_dig;
  logic [3:0]  mg_dp, mg_blk;
  int          m_mode, m_alt, m_hold, m_resume, m_cyc, m_ticks;
  logic [7:0]  m_seg;
  logic [3:0]  m_sel;
  logic [1:0]  m_src;
  logic        m_ack, m_busy;

  logic [15:0] obs_v, exp_v;
  assign obs_v = {msg_ack, msg_busy, active_src, sel, seg};
  assign exp_v = {m_ack, m_busy, m_src, m_sel, m_seg};

  // Advance the model by one clock edge using the inputs applied before it.
  task automatic model_edge();
    int         idx;
    bit         tk;
    logic [15:0] d;
    logic [3:0] dp, bl, nib;
    if (RST) begin
      m_seg = 8'h00; m_sel = 4'hf; m_src = 2'd0; m_ack = 1'b0; m_busy = 1'b0;
      for (int p = 0; p < 2; p++) begin
        pg_dig[p] = 16'h0000; pg_dp[p] = 4'h0; pg_blk[p] = 4'hf;
      end
      mg_dig = 16'h0000; mg_dp = 4'h0; mg_blk = 4'hf;
      m_mode = 0; m_alt = 0; m_hold = 0; m_resume = 1; m_cyc = 0; m_ticks = 0;
    end else begin
      tk = ((m_cyc % CLK_DIV) == CLK_DIV - 1);
      if (tk) begin
        idx = m_ticks % 4;
        if (m_mode == 0) begin
          m_seg = 8'h00; m_sel = 4'hf; m_src = 2'd0;
        end else begin
          if (m_mode == 3) begin
            d = mg_dig; dp = mg_dp; bl = mg_blk;
          end else begin
            d = pg_dig[m_mode-1]; dp = pg_dp[m_mode-1]; bl = pg_blk[m_mode-1];
          end
          nib = d[4*idx +: 4];
          m_seg = {dp[idx], bl[idx] ? 7'h00 : seg_tab[nib]};
          m_sel = ~(4'b0001 << idx);
          m_src = 2'(m_mode);
        end
      end
      m_ack = 1'b0;
      if (!enable) begin
        m_mode = 0; m_alt = 0; m_hold = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (msg_req) begin
        m_ack = 1'b1;
        if (m_mode != 3) m_resume = m_mode;
        m_mode = 3; m_hold = 0;
        mg_dig = msg_digits; mg_dp = msg_dp; mg_blk = msg_blank;
      end else if (tk) begin
        if (m_mode == 3) begin
          m_hold++;
          if (m_hold == HOLD_TICKS) begin m_hold = 0; m_mode = m_resume; end
        end else begin
          m_alt++;
          if (m_alt == ALT_TICKS) begin m_alt = 0; m_mode = 3 - m_mode; end
        end
      end
      m_busy = (m_mode == 3);
      if (bg_wr) begin
        pg_dig[bg_page] = bg_digits; pg_dp[bg_page] = bg_dp; pg_blk[bg_page] = bg_blank;
      end
      m_cyc++;
      if (tk) m_ticks++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enable = 1'($urandom_range(0, 1)); msg_req = 1'($urandom_range(0, 1));
      step();
      total++;
      if (obs_v !== 16'h0f00 || obs_v !== exp_v) begin
        bad++; $display("FAIL reset got=%h want=%h", obs_v, exp_v);
      end
    end
    enable = 1'b0; msg_req = 1'b0;
  endtask

  task automatic test_page_a();
    logic [7:0] es [4];
    logic [3:0] ss [4];
    es[0] = 8'h66; es[1] = 8'h4f; es[2] = 8'h5b; es[3] = 8'h06;
    ss[0] = 4'b1110; ss[1] = 4'b1101; ss[2] = 4'b1011; ss[3] = 4'b0111;
    RST = 1'b1; step(); RST = 1'b0;
    enable = 1'b1; bg_wr = 1'b1; bg_page = 1'b0;
    bg_digits = 16'h1234; bg_dp = 4'h0; bg_blank = 4'h0;
    for (int k = 1; k <= 20; k++) begin
      step(); bg_wr = 1'b0;
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL page_a cyc=%0d got=%h want=%h", m_cyc, obs_v, exp_v); end
      if (k % 4 == 0 && k <= 16) begin
        total++;
        if (seg !== es[k/4-1] || sel !== ss[k/4-1] || active_src !== 2'd1) begin
          bad++; $display("FAIL page_a_scan k=%0d got=%h/%b/%0d want=%h/%b/1", k, seg, sel, active_src, es[k/4-1], ss[k/4-1]);
        end
      end
    end
  endtask

  task automatic test_page_b();
    bit saw_ff, saw_00, saw_back_a;
    saw_ff = 1'b0; saw_00 = 1'b0; saw_back_a = 1'b0;
    bg_wr = 1'b1; bg_page = 1'b1; bg_digits = 16'h0987; bg_dp = 4'b0010; bg_blank = 4'b1000;
    step(); bg_wr = 1'b0;
    for (int k = 0; k < 2*ALT_TICKS*CLK_DIV + 16; k++) begin
      step();
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL page_b cyc=%0d got=%h want=%h", m_cyc, obs_v, exp_v); end
      if (active_src == 2'd2 && sel == 4'b1101 && seg == 8'hff) saw_ff = 1'b1;
      if (active_src == 2'd2 && sel == 4'b0111 && seg == 8'h00) saw_00 = 1'b1;
      if (saw_ff && active_src == 2'd1) saw_back_a = 1'b1;
    end
    total++;
    if ({saw_ff, saw_00, saw_back_a} !== 3'b111) begin
      bad++; $display("FAIL page_b_pattern got=%b want=111", {saw_ff, saw_00, saw_back_a});
    end
  endtask

  task automatic test_msg();
    int guard, acks;
    guard = 0; acks = 0;
    while (!(m_mode == 1 && m_alt == 5) && guard < 400) begin
      step(); guard++;
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL msg_pre cyc=%0d got=%h want=%h", m_cyc, obs_v, exp_v); end
    end
    total++;
    if (guard >= 400) begin bad++; $display("FAIL msg_wait got=timeout want=page A alt 5"); end
    msg_req = 1'b1; msg_digits = 16'h00ab; msg_dp = 4'h0; msg_blank = 4'b1100;
    for (int k = 0; k < (HOLD_TICKS + 11) * CLK_DIV + 24; k++) begin
      step(); msg_req = 1'b0;
      if (msg_ack) acks++;
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL msg cyc=%0d got=%h want=%h", m_cyc, obs_v, exp_v); end
    end
    total++;
    if (acks !== 1) begin bad++; $display("FAIL msg_ack_count got=%0d want=1", acks); end
  endtask

  task automatic test_retrigger();
    int guard, acks;
    guard = 0; acks = 0;
    while (!(m_mode == 1 || m_mode == 2) && guard < 200) begin step(); guard++; end
    msg_req = 1'b1; msg_digits = 16'($urandom); msg_dp = 4'($urandom); msg_blank = 4'h0;
    step(); msg_req = 1'b0;
    if (msg_ack) acks++;
    guard = 0;
    while (!(m_mode == 3 && m_hold == 5) && guard < 100) begin
      step(); guard++;
      if (msg_ack) acks++;
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL retrig_pre cyc=%0d got=%h want=%h", m_cyc, obs_v, exp_v); end
    end
    msg_req = 1'b1; msg_digits = 16'h4e21; msg_dp = 4'b1001;
    for (int k = 0; k < (HOLD_TICKS + 4) * CLK_DIV + 40; k++) begin
      step(); msg_req = 1'b0;
      if (msg_ack) acks++;
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL retrig cyc=%0d got=%h want=%h", m_cyc, obs_v, exp_v); end
    end
    total++;
    if (acks !== 2) begin bad++; $display("FAIL retrig_ack_count got=%0d want=2", acks); end
  endtask

  task automatic test_enable_drop();
    msg_req = 1'b1; msg_digits = 16'hbeef; msg_dp = 4'h0; msg_blank = 4'h0;
    step(); msg_req = 1'b0;
    for (int k = 0; k < 6; k++) step();
    enable = 1'b0;
    step();
    total++;
    if (msg_busy !== 1'b0 || obs_v !== exp_v) begin
      bad++; $display("FAIL en_drop_busy got=%h want=%h", obs_v, exp_v);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL en_drop cyc=%0d got=%h want=%h", m_cyc, obs_v, exp_v); end
    end
    total++;
    if ({active_src, sel, seg} !== 14'h0f00) begin
      bad++; $display("FAIL en_drop_blank got=%h want=0f00", {active_src, sel, seg});
    end
    enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step();
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL re_enable cyc=%0d got=%h want=%h", m_cyc, obs_v, exp_v); end
    end
  endtask

  task automatic test_reset_mid();
    msg_req = 1'b1; msg_digits = 16'h1357; msg_dp = 4'hf; msg_blank = 4'h0;
    step(); msg_req = 1'b0;
    for (int k = 0; k < 5; k++) step();
    RST = 1'b1;
    step();
    total++;
    if (obs_v !== 16'h0f00) begin bad++; $display("FAIL reset_mid got=%h want=0f00", obs_v); end
    RST = 1'b0; enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step();
      total++;
      if (obs_v !== exp_v || seg !== 8'h00) begin
        bad++; $display("FAIL reset_mid_blank cyc=%0d got=%h want=%h", m_cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      RST    = ($urandom_range(0, 999) == 0);
      enable = ($urandom_range(0, 199) != 0);
      bg_wr  = ($urandom_range(0, 19) == 0);
      bg_page = 1'($urandom); bg_digits = 16'($urandom);
      bg_dp = 4'($urandom); bg_blank = 4'($urandom);
      if (msg_req && msg_ack) begin
        msg_req = 1'b0;
      end else if (!msg_req && $urandom_range(0, 39) == 0) begin
        msg_req = 1'b1; msg_digits = 16'($urandom);
        msg_dp = 4'($urandom); msg_blank = 4'($urandom);
      end
      step();
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", m_cyc, obs_v, exp_v); end
    end
    RST = 1'b0; bg_wr = 1'b0; msg_req = 1'b0; enable = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0;
    seg_tab[0]  = 7'h3f; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5b; seg_tab[3]  = 7'h4f;
    seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6d; seg_tab[6]  = 7'h7d; seg_tab[7]  = 7'h07;
    seg_tab[8]  = 7'h7f; seg_tab[9]  = 7'h6f; seg_tab[10] = 7'h77; seg_tab[11] = 7'h7c;
    seg_tab[12] = 7'h39; seg_tab[13] = 7'h5e; seg_tab[14] = 7'h79; seg_tab[15] = 7'h71;
    RST = 1'b1; enable = 1'b0; bg_wr = 1'b0; bg_page = 1'b0;
    bg_digits = 16'h0000; bg_dp = 4'h0; bg_blank = 4'h0;
    msg_req = 1'b0; msg_digits = 16'h0000; msg_dp = 4'h0; msg_blank = 4'h0;
    @(negedge clk);
    test_reset();
    test_page_a();
    test_page_b();
    test_msg();
    test_retrigger();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
